execute_cc_stage: RTL
=====================

EXECUTE_CC_STAGE -- requirements
Module: execute_cc_stage

Interface
REQ-001 SHALL have parameter: WIDTH, 64, datapath width in bits (all values below assume 64).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  upstream presents an instruction.
REQ-005 SHALL have port: in_ready  output  1  stage can accept this cycle.
REQ-006 SHALL have port: icode  input  4  Y86 instruction code.
REQ-007 SHALL have port: ifun  input  4  Y86 function code.
REQ-008 SHALL have port: val_a  input  WIDTH  operand A, signed two's complement.
REQ-009 SHALL have port: val_b  input  WIDTH  operand B, signed two's complement.
REQ-010 SHALL have port: out_valid  output  1  registered result valid.
REQ-011 SHALL have port: out_ready  input  1  downstream consumes result.
REQ-012 SHALL have port: val_e  output  WIDTH  registered execute result.
REQ-013 SHALL have port: cnd  output  1  registered condition outcome.
REQ-014 SHALL have ports: zf, sf, of  output  1 each  condition-code register contents.

Function
REQ-015 SHALL accept an instruction when in_valid & in_ready at a rising clk edge; in_ready = ~out_valid | out_ready.
REQ-016 SHALL present the result of an accepted instruction on val_e/cnd with out_valid=1 exactly one cycle after acceptance.
REQ-017 SHALL hold val_e, cnd, out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL, on simultaneous drain (out_ready=1) and accept, load the new result in that same edge with out_valid remaining 1; drain without accept clears out_valid.
REQ-019 SHALL for icode 6 (OPq) compute val_e per ifun: 0 val_b+val_a, 1 val_b-val_a, 2 val_b&val_a, 3 val_b^val_a, modulo 2^64.
REQ-020 SHALL set OF for add when operand signs equal and result sign differs; for sub when val_b, val_a signs differ and result sign differs from val_b; OF=0 for and/xor.
REQ-021 SHALL update zf (result==0), sf (result[63]), of at the acceptance edge of a valid OPq (ifun 0..3) only.
REQ-022 SHALL for OPq with ifun>3 produce val_e=0, cnd=0, CC unchanged.
REQ-023 SHALL for icode 2 (cmovXX) and 7 (jXX) evaluate cnd from CC held at acceptance, which reflects every previously accepted OPq: ifun 0 1; 1 (sf^of)|zf; 2 sf^of; 3 zf; 4 ~zf; 5 ~(sf^of); 6 ~(sf^of)&~zf; >6 0.
REQ-024 SHALL for cmovXX produce val_e=val_a; for jXX val_e=0.
REQ-025 SHALL for icode 3, 4, 5 produce val_e=val_b+val_a, cnd=0, CC unchanged.
REQ-026 SHALL for any other icode produce val_e=0, cnd=0, CC unchanged.
REQ-027 SHALL not update CC or state for instructions not accepted (in_valid=0 or in_ready=0).

Reset
REQ-028 SHALL, while rst=1, immediately force out_valid=0, val_e=0, cnd=0, zf=1, sf=0, of=0, regardless of clk.
REQ-029 SHALL discard any pending result on reset mid-operation; in_ready=1 after rst deasserts.

Verification
REQ-030 SHALL cover: OPq add, val_a=val_b=0x7FFFFFFFFFFFFFFF -> val_e=0xFFFFFFFFFFFFFFFE, of=1, sf=1, zf=0.
REQ-031 SHALL cover: OPq add, val_a=val_b=-9223372036854775805 -> val_e=6, of=1, sf=0, zf=0.
REQ-032 SHALL cover: OPq sub, val_a=val_b=5 -> val_e=0, zf=1; next jXX ifun 3 -> cnd=1, val_e=0.
REQ-033 SHALL cover: OPq xor, val_b=-5, val_a=107 -> val_e=0xFFFFFFFFFFFFFF90, sf=1, of=0; next cmovXX ifun 2, val_a=42 -> cnd=1, val_e=42.
REQ-034 SHALL cover: out_ready=0 for 2 cycles with in_valid=1 -> in_ready=0, val_e stable; next instruction accepted on edge where out_ready=1, result next cycle.
REQ-035 SHALL cover: rst asserted mid-cycle while out_valid=1 -> out_valid=0, zf=1, sf=0, of=0 before next clk edge.

Source files
------------

// File: rtl/execute_cc_if.sv
// Handshake and result bus between the decode side and the Y86 execute stage.
// The master drives instructions and consumes results; the slave is the stage.
interface execute_cc_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [WIDTH-1:0] val_a;
    logic [WIDTH-1:0] val_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] val_e;
    logic             cnd;
    logic             zf;
    logic             sf;
    logic             of;

    modport master (
        output in_valid, icode, ifun, val_a, val_b, out_ready,
        input  in_ready, out_valid, val_e, cnd, zf, sf, of
    );

    modport slave (
        input  in_valid, icode, ifun, val_a, val_b, out_ready,
        output in_ready, out_valid, val_e, cnd, zf, sf, of
    );
endinterface

// File: rtl/execute_cc_stage.sv
// Y86 execute stage: ALU, condition-code register and branch/cmov condition
// evaluation, with a single registered output slot under valid/ready flow control.
module execute_cc_stage #(
    parameter int WIDTH = 64
) (
    input logic         clk,
    input logic         rst,
    execute_cc_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;

    localparam logic [3:0] F_ADD = 4'h0;
    localparam logic [3:0] F_SUB = 4'h1;
    localparam logic [3:0] F_AND = 4'h2;
    localparam logic [3:0] F_XOR = 4'h3;

    logic             accept;
    logic             cond_true;
    logic [WIDTH-1:0] alu_res;
    logic             nxt_cnd;
    logic             nxt_of;
    logic             cc_we;

    // The output slot frees up either when empty or when drained this edge.
    assign bus.in_ready = ~bus.out_valid | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;

    // Condition evaluated against the CC register as it stands before this edge.
    always_comb begin
        case (bus.ifun)
            4'h0:    cond_true = 1'b1;
            4'h1:    cond_true = (bus.sf ^ bus.of) | bus.zf;
            4'h2:    cond_true = bus.sf ^ bus.of;
            4'h3:    cond_true = bus.zf;
            4'h4:    cond_true = ~bus.zf;
            4'h5:    cond_true = ~(bus.sf ^ bus.of);
            4'h6:    cond_true = ~(bus.sf ^ bus.of) & ~bus.zf;
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        alu_res = '0;
        nxt_cnd = 1'b0;
        nxt_of  = 1'b0;
        cc_we   = 1'b0;
        case (bus.icode)
            I_OPQ: begin
                case (bus.ifun)
                    F_ADD: begin
                        alu_res = bus.val_b + bus.val_a;
                        nxt_of  = (bus.val_a[MSB] == bus.val_b[MSB]) &&
                                  (alu_res[MSB] != bus.val_b[MSB]);
                        cc_we   = 1'b1;
                    end
                    F_SUB: begin
                        alu_res = bus.val_b - bus.val_a;
                        nxt_of  = (bus.val_a[MSB] != bus.val_b[MSB]) &&
                                  (alu_res[MSB] != bus.val_b[MSB]);
                        cc_we   = 1'b1;
                    end
                    F_AND: begin
                        alu_res = bus.val_b & bus.val_a;
                        cc_we   = 1'b1;
                    end
                    F_XOR: begin
                        alu_res = bus.val_b ^ bus.val_a;
                        cc_we   = 1'b1;
                    end
                    default: ;
                endcase
            end
            I_CMOVXX: begin
                alu_res = bus.val_a;
                nxt_cnd = cond_true;
            end
            I_JXX: nxt_cnd = cond_true;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_res = bus.val_b + bus.val_a;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.val_e     <= '0;
            bus.cnd       <= 1'b0;
            bus.zf        <= 1'b1;
            bus.sf        <= 1'b0;
            bus.of        <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking so CC reads above see pre-edge values while all state updates together.
            bus.out_valid <= 1'b1;
            bus.val_e     <= alu_res;
            bus.cnd       <= nxt_cnd;
            if (cc_we) begin
                bus.zf <= (alu_res == '0);
                bus.sf <= alu_res[MSB];
                bus.of <= nxt_of;
            end
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
